// File: rtl/nexys_starship_monster_bank_if.sv
// Signal bundle for the monster bank: player/timer inputs and the game-state outputs.
interface nexys_starship_monster_bank_if #(
  parameter int N_CH    = 4,
  parameter int SCORE_W = 8
);
  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                tick;
  logic                play_flag;
  logic [N_CH-1:0]     rand_in;
  logic [N_CH-1:0]     kill;
  logic [N_CH-1:0]     monster;
  logic [CNT_W-1:0]    active_count;
  logic                gameover;
  logic [CH_W-1:0]     gameover_ch;
  logic [SCORE_W-1:0]  score;
  logic                q_Idle;
  logic                q_Play;
  logic                q_Over;

  modport master (
    output tick, play_flag, rand_in, kill,
    input  monster, active_count, gameover, gameover_ch, score, q_Idle, q_Play, q_Over
  );

  modport slave (
    input  tick, play_flag, rand_in, kill,
    output monster, active_count, gameover, gameover_ch, score, q_Idle, q_Play, q_Over
  );
endinterface

// File: rtl/nexys_starship_monster_bank.sv
// Whack-a-monster terminal bank: per-terminal spawn/timeout timers, global spawn limit,
// saturating kill score and an IDLE/PLAY/OVER game FSM.
module nexys_starship_monster_bank #(
  parameter int N_CH        = 4,
  parameter int TIMEOUT     = 15,
  parameter int SPAWN_DELAY = 1,
  parameter int MAX_ACTIVE  = 2,
  parameter int SCORE_W     = 8
) (
  input  logic Clk,
  input  logic Reset,
  nexys_starship_monster_bank_if.slave bus
);
  localparam int CNT_W = $clog2(N_CH + 1);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW    = 8;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t state, state_nxt;

  logic [N_CH-1:0]          monster_r, monster_nxt, spawn, cand, to_vec, live_kill;
  logic [N_CH-1:0][TW-1:0]  timer, delay;
  logic [CNT_W-1:0]         act_r, left;
  logic [CH_W-1:0]          go_ch_r, to_idx;
  logic [SCORE_W-1:0]       score_r, score_nxt;
  logic [SCORE_W+3:0]       score_sum;
  logic                     any_to, start;

  function automatic logic [CNT_W-1:0] popcnt(input logic [N_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_CH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Per-terminal status; timeouts are only meaningful while playing
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cand[i]      = !monster_r[i] && (delay[i] == TW'(SPAWN_DELAY)) && bus.rand_in[i];
      to_vec[i]    = (state == PLAY) && monster_r[i] && bus.tick &&
                     (timer[i] == TW'(TIMEOUT - 1)) && !bus.kill[i];
      live_kill[i] = monster_r[i] && bus.kill[i];
    end
    any_to = |to_vec;
    start  = (state == IDLE) && bus.play_flag;
  end

  // Lowest-index timeout and lowest-index-first spawn grants against the registered count
  always_comb begin
    to_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (to_vec[i]) to_idx = CH_W'(i);
    spawn = '0;
    left  = CNT_W'(MAX_ACTIVE) - act_r;
    for (int i = 0; i < N_CH; i++)
      if (cand[i] && left != '0) begin
        spawn[i] = 1'b1;
        left     = left - 1'b1;
      end
    monster_nxt = (monster_r & ~bus.kill) | spawn;
    score_sum   = {4'b0, score_r} + (SCORE_W + 4)'(popcnt(live_kill));
    score_nxt   = (score_sum > {4'b0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.play_flag)  state_nxt = PLAY;
      PLAY:    if (any_to)         state_nxt = OVER;
      OVER:    if (!bus.play_flag) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.q_Idle   = (state == IDLE);
    bus.q_Play   = (state == PLAY);
    bus.q_Over   = (state == OVER);
    bus.gameover = (state == OVER);
  end

  always_ff @(posedge Clk) begin
    if (Reset || start) begin
      monster_r <= '0;
      act_r     <= '0;
      score_r   <= '0;
      go_ch_r   <= '0;
    end else if (state == PLAY) begin
      if (any_to) begin
        monster_r <= '0;
        act_r     <= '0;
        go_ch_r   <= to_idx;
      end else begin
        monster_r <= monster_nxt;
        act_r     <= popcnt(monster_nxt);
        score_r   <= score_nxt;
      end
    end
  end

  // A kill re-arms the spawn delay; timers freeze on the timeout cycle
  always_ff @(posedge Clk) begin
    if (Reset || start) begin
      timer <= '0;
      delay <= '0;
    end else if (state == PLAY && !any_to) begin
      for (int i = 0; i < N_CH; i++) begin
        if (monster_r[i]) begin
          if (bus.kill[i])   delay[i] <= '0;
          else if (bus.tick) timer[i] <= timer[i] + 1'b1;
        end else if (spawn[i]) begin
          timer[i] <= '0;
        end else if (bus.tick && delay[i] != TW'(SPAWN_DELAY)) begin
          delay[i] <= delay[i] + 1'b1;
        end
      end
    end
  end

  assign bus.monster      = monster_r;
  assign bus.active_count = act_r;
  assign bus.gameover_ch  = go_ch_r;
  assign bus.score        = score_r;
endmodule

// File: tb/tb_nexys_starship_monster_bank.sv
// Directed checks of the monster bank; a 2-bit-score copy shadows the same stimulus.
module tb_nexys_starship_monster_bank;
  logic Clk = 1'b0;
  logic Reset;
  int   nchk = 0;
  int   errs = 0;

  nexys_starship_monster_bank_if #(.N_CH(4), .SCORE_W(8)) ba ();
  nexys_starship_monster_bank_if #(.N_CH(4), .SCORE_W(2)) bb ();

  nexys_starship_monster_bank #(.N_CH(4), .SCORE_W(8)) dut_a (.Clk(Clk), .Reset(Reset), .bus(ba));
  nexys_starship_monster_bank #(.N_CH(4), .SCORE_W(2)) dut_b (.Clk(Clk), .Reset(Reset), .bus(bb));

  assign bb.tick      = ba.tick;
  assign bb.play_flag = ba.play_flag;
  assign bb.rand_in   = ba.rand_in;
  assign bb.kill      = ba.kill;

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_tick();
    ba.tick = 1'b1;
    cyc();
    ba.tick = 1'b0;
  endtask

  task automatic new_game();
    Reset = 1'b1; ba.play_flag = 1'b0; ba.tick = 1'b0; ba.rand_in = '0; ba.kill = '0;
    cyc();
    Reset = 1'b0; ba.play_flag = 1'b1;
    cyc();
  endtask

  initial begin
    Reset = 1'b1; ba.play_flag = 1'b0; ba.tick = 1'b0; ba.rand_in = '0; ba.kill = '0;
    cyc(); cyc();
    chk("rst_monster", ba.monster, 0);
    chk("rst_active", ba.active_count, 0);
    chk("rst_score", ba.score, 0);
    chk("rst_gameover", ba.gameover, 0);
    chk("rst_idle", ba.q_Idle, 1);

    // single spawn after the delay is armed
    Reset = 1'b0; ba.play_flag = 1'b1;
    cyc();
    chk("play_entry", ba.q_Play, 1);
    ba.rand_in = 4'b0001;
    do_tick();
    chk("not_armed", ba.monster, 0);
    cyc();
    chk("spawn_one", ba.monster, 4'b0001);
    chk("spawn_one_cnt", ba.active_count, 1);

    // spawn limit, kill, delayed reuse of a freed slot
    new_game();
    do_tick();
    ba.rand_in = 4'b1111;
    cyc();
    chk("limit_mon", ba.monster, 4'b0011);
    chk("limit_cnt", ba.active_count, 2);
    cyc();
    chk("limit_hold", ba.monster, 4'b0011);
    ba.kill = 4'b0101;
    cyc();
    ba.kill = '0;
    chk("kill_mon", ba.monster, 4'b0010);
    chk("kill_score", ba.score, 1);
    cyc();
    chk("refill", ba.monster, 4'b0110);
    chk("refill_cnt", ba.active_count, 2);

    // timeout on ch2, with a simultaneous spawn request that must be dropped
    new_game();
    ba.rand_in = 4'b0100;
    do_tick();
    cyc();
    ba.rand_in = '0;
    chk("to_spawn", ba.monster, 4'b0100);
    for (int i = 0; i < 14; i++) do_tick();
    chk("to_before", ba.gameover, 0);
    chk("to_before_mon", ba.monster, 4'b0100);
    ba.rand_in = 4'b0001;
    do_tick();
    ba.rand_in = '0;
    chk("to_gameover", ba.gameover, 1);
    chk("to_ch", ba.gameover_ch, 2);
    chk("to_mon", ba.monster, 0);
    chk("to_qover", ba.q_Over, 1);
    ba.kill = 4'b0100;
    cyc();
    ba.kill = '0;
    chk("over_kill_ign", ba.score, 0);
    chk("over_stays", ba.q_Over, 1);
    ba.play_flag = 1'b0;
    cyc();
    chk("over_to_idle", ba.q_Idle, 1);
    chk("idle_gameover", ba.gameover, 0);

    // kill on the 15th tick beats the timeout
    new_game();
    ba.rand_in = 4'b0100;
    do_tick();
    cyc();
    ba.rand_in = '0;
    for (int i = 0; i < 14; i++) do_tick();
    ba.kill = 4'b0100;
    do_tick();
    ba.kill = '0;
    chk("save_gameover", ba.gameover, 0);
    chk("save_score", ba.score, 1);
    chk("save_mon", ba.monster, 0);

    // two simultaneous timeouts report the lowest index
    new_game();
    ba.rand_in = 4'b1010;
    do_tick();
    cyc();
    ba.rand_in = '0;
    chk("dual_mon", ba.monster, 4'b1010);
    for (int i = 0; i < 15; i++) do_tick();
    chk("dual_over", ba.gameover, 1);
    chk("dual_ch", ba.gameover_ch, 1);

    // score accumulation, saturation on the 2-bit copy, reset mid-game
    new_game();
    ba.rand_in = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      do_tick();
      cyc();
      ba.kill = 4'b0001;
      cyc();
      ba.kill = '0;
      if (k == 2) chk("sat_b_3", bb.score, 3);
    end
    chk("score5", ba.score, 5);
    chk("sat_b", bb.score, 3);
    ba.rand_in = 4'b0011;
    do_tick();
    cyc();
    ba.rand_in = '0;
    chk("pre_rst_mon", ba.monster, 4'b0011);
    Reset = 1'b1;
    cyc();
    chk("mid_rst_idle", ba.q_Idle, 1);
    chk("mid_rst_mon", ba.monster, 0);
    chk("mid_rst_score", ba.score, 0);
    chk("mid_rst_cnt", ba.active_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, errs);
    $finish;
  end
endmodule

// File: doc/nexys_starship_monster_bank.md
NEXYS_STARSHIP_MONSTER_BANK -- requirements
Module: nexys_starship_monster_bank

Interface
REQ-001 Parameter: N_CH, 4, number of monster terminals (1..8).
REQ-002 Parameter: TIMEOUT, 15, ticks a monster may stay unkilled before game over (2..255).
REQ-003 Parameter: SPAWN_DELAY, 1, ticks a terminal stays empty before it is armed for spawning (0..255).
REQ-004 Parameter: MAX_ACTIVE, 2, maximum simultaneous monsters across all terminals (1..N_CH).
REQ-005 Parameter: SCORE_W, 8, score counter width.
REQ-006 Port: Clk  input  1  single system clock; all logic on its rising edge.
REQ-007 Port: Reset  input  1  synchronous, active-high reset.
REQ-008 Port: tick  input  1  one-Clk-wide timer enable pulse; all timers advance only on tick.
REQ-009 Port: play_flag  input  1  level; high requests play, low returns from game over.
REQ-010 Port: rand_in  input  N_CH  per-terminal random spawn request, sampled every Clk.
REQ-011 Port: kill  input  N_CH  per-terminal kill pulse from the player.
REQ-012 Port: monster  output  N_CH  registered; bit i high while terminal i holds a monster.
REQ-013 Port: active_count  output  clog2(N_CH+1)  registered popcount of monster.
REQ-014 Port: gameover  output  1  registered; high in OVER state.
REQ-015 Port: gameover_ch  output  clog2(N_CH) (min 1)  index of terminal that timed out; held in OVER.
REQ-016 Port: score  output  SCORE_W  registered kill count, saturating.
REQ-017 Port: q_Idle, q_Play, q_Over  output  1 each  one-hot top state.

Function
REQ-018 Top FSM: IDLE -> PLAY when play_flag=1; PLAY -> OVER on any timeout; OVER -> IDLE when play_flag=0; no other transitions.
REQ-019 IDLE->PLAY edge: clear score, monster, all timers, all delay counters, gameover_ch.
REQ-020 Per terminal i in PLAY: EMPTY (monster[i]=0) or FULL (monster[i]=1).
REQ-021 EMPTY: delay[i] increments on tick, saturating at SPAWN_DELAY; armed[i] = (delay[i] == SPAWN_DELAY).
REQ-022 Spawn candidate: EMPTY, armed[i], rand_in[i]=1; monster[i] sets next cycle, timer[i] cleared.
REQ-023 Spawn limit: grants = MAX_ACTIVE - active_count (registered value) per cycle, lowest index first; ungranted candidates stay EMPTY and armed.
REQ-024 FULL: timer[i] increments on tick; timeout when tick=1, timer[i]=TIMEOUT-1 and kill[i]=0.
REQ-025 kill[i] in FULL: clear monster[i] and delay[i] next cycle, score += 1 saturating at 2^SCORE_W-1.
REQ-026 kill[i] in EMPTY, IDLE or OVER: ignored, no score change.
REQ-027 Kill and timeout same cycle on one terminal: kill wins.
REQ-028 Timeouts on several terminals same cycle: gameover_ch = lowest index.
REQ-029 Timeout and spawn same cycle: timeout wins, no spawn recorded.
REQ-030 On entry to OVER: monster cleared, timers frozen, score held, gameover=1.
REQ-031 A slot freed by a kill is usable for spawning no earlier than the following cycle.
REQ-032 Without tick: no timer or delay changes; kills and spawns still act per Clk.

Reset
REQ-033 Reset=1 at a Clk edge: state IDLE, monster=0, active_count=0, gameover=0, gameover_ch=0, score=0, all counters 0; takes priority over every other input, including mid-game.

Verification
REQ-034 Defaults, play_flag=1, rand_in=4'b0001 after 1 tick -> monster=4'b0001, active_count=1.
REQ-035 rand_in=4'b1111, all armed, active_count=0 -> monster=4'b0011 only (MAX_ACTIVE=2).
REQ-036 Monster on ch2, 15 ticks without kill -> gameover=1, gameover_ch=2, monster=0, q_Over=1.
REQ-037 kill[2] on the cycle of the 15th tick -> no game over, score=1, monster[2]=0.
REQ-038 SCORE_W=2, four kills -> score=3 (saturated).
REQ-039 Reset during PLAY with 2 monsters and score=5 -> next cycle q_Idle=1, monster=0, score=0.
